// File: rtl/beat_packer.sv
// Packs N consecutive L-bit valid/ready beats into one N*L-bit word, little-endian by arrival.
// A last_f marker closes a partial word early; the packed word sits in a registered output stage.
module beat_packer #(
  parameter int L = 8,
  parameter int N = 4
) (
  input  logic           clk,
  input  logic           rst,
  output logic           ready_f,
  input  logic           valid_f,
  input  logic [L-1:0]   data_f,
  input  logic           last_f,
  input  logic           ready_b,
  output logic           valid_b,
  output logic [N*L-1:0] data_b,
  output logic [N-1:0]   keep_b,
  output logic           last_b
);

  localparam int CW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic {EMPTY, FULL} state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [N*L-1:0]   acc_q, acc_d;
  logic [N*L-1:0]   data_b_q, data_b_d;
  logic [N-1:0]     keep_b_q, keep_b_d;
  logic             last_b_q, last_b_d;

  logic [N*L-1:0]   merged;
  logic [N-1:0]     mask;
  logic             accept;
  logic             complete;

  // Input stalls whenever a packed word is waiting, regardless of the input side.
  assign ready_f  = !rst && (state_q == EMPTY || ready_b);
  assign accept   = valid_f && ready_f;
  assign complete = accept && ((cnt_q == CW'(N - 1)) || last_f);

  // Current beat dropped into lane cnt; lanes above cnt forced to zero.
  always_comb begin
    merged = '0;
    mask   = '0;
    for (int i = 0; i < N; i++) begin
      if (CW'(i) < cnt_q) begin
        merged[i*L +: L] = acc_q[i*L +: L];
      end else if (CW'(i) == cnt_q) begin
        merged[i*L +: L] = data_f;
      end
      mask[i] = (CW'(i) <= cnt_q);
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    data_b_d = data_b_q;
    keep_b_d = keep_b_q;
    last_b_d = last_b_q;
    if (complete) begin
      state_d  = FULL;
      data_b_d = merged;
      keep_b_d = mask;
      last_b_d = last_f;
      cnt_d    = '0;
      acc_d    = '0;
    end else begin
      if (accept) begin
        acc_d = merged;
        cnt_d = cnt_q + CW'(1);
      end
      if (state_q == FULL && ready_b) begin
        state_d = EMPTY;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= EMPTY;
      cnt_q    <= '0;
      acc_q    <= '0;
      data_b_q <= '0;
      keep_b_q <= '0;
      last_b_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      data_b_q <= data_b_d;
      keep_b_q <= keep_b_d;
      last_b_q <= last_b_d;
    end
  end

  assign valid_b = (state_q == FULL);
  assign data_b  = data_b_q;
  assign keep_b  = keep_b_q;
  assign last_b  = last_b_q;

endmodule

// File: tb/tb_beat_packer.sv
// Directed bench for beat_packer: an L=8/N=4 instance for the main scenarios and an N=2 instance
// for the smallest legal word size.
module tb_beat_packer;

  logic        clk = 1'b0;
  logic        rst;

  logic        ready_f, valid_f, last_f, ready_b, valid_b, last_b;
  logic [7:0]  data_f;
  logic [31:0] data_b;
  logic [3:0]  keep_b;

  logic        r2, v2, l2, rb2, vb2, lb2;
  logic [7:0]  d2;
  logic [15:0] db2;
  logic [1:0]  kb2;

  int errors = 0;
  int checks = 0;

  beat_packer #(.L(8), .N(4)) dut (
    .clk(clk), .rst(rst), .ready_f(ready_f), .valid_f(valid_f), .data_f(data_f),
    .last_f(last_f), .ready_b(ready_b), .valid_b(valid_b), .data_b(data_b),
    .keep_b(keep_b), .last_b(last_b)
  );

  beat_packer #(.L(8), .N(2)) dut2 (
    .clk(clk), .rst(rst), .ready_f(r2), .valid_f(v2), .data_f(d2),
    .last_f(l2), .ready_b(rb2), .valid_b(vb2), .data_b(db2),
    .keep_b(kb2), .last_b(lb2)
  );

  always #5 clk = ~clk;

  // Drives one beat for one edge; outputs are sampled 1 time unit after that edge.
  task automatic drive_beat(input logic [7:0] d, input logic l);
    valid_f = 1'b1;
    data_f  = d;
    last_f  = l;
    @(posedge clk);
    #1;
    valid_f = 1'b0;
    last_f  = 1'b0;
  endtask

  task automatic idle_cycle();
    valid_f = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    valid_f = 1'b0; data_f = 8'h00; last_f = 1'b0; ready_b = 1'b1;
    v2 = 1'b0; d2 = 8'h00; l2 = 1'b0; rb2 = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (ready_f !== 1'b0) begin errors++; $display("[TB] FAIL reset_ready_f got=%b exp=0", ready_f); end
    checks++;
    if (valid_b !== 1'b0) begin errors++; $display("[TB] FAIL reset_valid_b got=%b exp=0", valid_b); end
    checks++;
    if (data_b !== 32'h0 || keep_b !== 4'h0 || last_b !== 1'b0) begin
      errors++; $display("[TB] FAIL reset_outputs got data=%h keep=%b last=%b exp 0/0/0", data_b, keep_b, last_b);
    end
    rst = 1'b0;
    #1;
    checks++;
    if (ready_f !== 1'b1) begin errors++; $display("[TB] FAIL post_reset_ready_f got=%b exp=1", ready_f); end
  endtask

  task automatic test_full_words();
    logic [31:0] exp_word [2];
    exp_word[0] = 32'h04030201;
    exp_word[1] = 32'h08070605;
    ready_b = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      valid_f = 1'b1;
      data_f  = 8'(i);
      last_f  = 1'b0;
      #1;
      checks++;
      if (ready_f !== 1'b1) begin errors++; $display("[TB] FAIL full_ready_f beat=%0d got=%b exp=1", i, ready_f); end
      @(posedge clk);
      #1;
      checks++;
      if (valid_b !== ((i % 4) == 0)) begin
        errors++; $display("[TB] FAIL full_valid_b beat=%0d got=%b exp=%b", i, valid_b, ((i % 4) == 0));
      end
      if ((i % 4) == 0) begin
        checks++;
        if (data_b !== exp_word[i/4 - 1] || keep_b !== 4'b1111 || last_b !== 1'b0) begin
          errors++;
          $display("[TB] FAIL full_word beat=%0d got data=%h keep=%b last=%b exp data=%h keep=1111 last=0",
                   i, data_b, keep_b, last_b, exp_word[i/4 - 1]);
        end
      end
    end
    idle_cycle();
    checks++;
    if (valid_b !== 1'b0) begin errors++; $display("[TB] FAIL full_drain got=%b exp=0", valid_b); end
  endtask

  task automatic test_partial_flush();
    ready_b = 1'b1;
    drive_beat(8'hAA, 1'b0);
    drive_beat(8'hBB, 1'b1);
    checks++;
    if (valid_b !== 1'b1 || data_b !== 32'h0000BBAA || keep_b !== 4'b0011 || last_b !== 1'b1) begin
      errors++;
      $display("[TB] FAIL flush_word got v=%b data=%h keep=%b last=%b exp v=1 data=0000bbaa keep=0011 last=1",
               valid_b, data_b, keep_b, last_b);
    end
    drive_beat(8'hCC, 1'b1);
    checks++;
    if (valid_b !== 1'b1 || data_b !== 32'h000000CC || keep_b !== 4'b0001 || last_b !== 1'b1) begin
      errors++;
      $display("[TB] FAIL flush_next_lane0 got v=%b data=%h keep=%b last=%b exp v=1 data=000000cc keep=0001 last=1",
               valid_b, data_b, keep_b, last_b);
    end
    idle_cycle();
  endtask

  task automatic test_backpressure();
    ready_b = 1'b0;
    drive_beat(8'h01, 1'b0);
    drive_beat(8'h02, 1'b0);
    drive_beat(8'h03, 1'b0);
    drive_beat(8'h04, 1'b0);
    checks++;
    if (valid_b !== 1'b1 || data_b !== 32'h04030201) begin
      errors++; $display("[TB] FAIL bp_word got v=%b data=%h exp v=1 data=04030201", valid_b, data_b);
    end
    for (int c = 0; c < 5; c++) begin
      valid_f = 1'b1;
      data_f  = 8'hEE;
      last_f  = 1'b1;
      #1;
      checks++;
      if (ready_f !== 1'b0) begin errors++; $display("[TB] FAIL bp_ready_f cycle=%0d got=%b exp=0", c, ready_f); end
      @(posedge clk);
      #1;
      checks++;
      if (valid_b !== 1'b1 || data_b !== 32'h04030201 || keep_b !== 4'b1111 || last_b !== 1'b0) begin
        errors++;
        $display("[TB] FAIL bp_hold cycle=%0d got v=%b data=%h keep=%b last=%b exp v=1 data=04030201 keep=1111 last=0",
                 c, valid_b, data_b, keep_b, last_b);
      end
    end
    valid_f = 1'b0;
    last_f  = 1'b0;
    ready_b = 1'b1;
    #1;
    checks++;
    if (ready_f !== 1'b1) begin errors++; $display("[TB] FAIL bp_release_ready_f got=%b exp=1", ready_f); end
    @(posedge clk);
    #1;
    checks++;
    if (valid_b !== 1'b0) begin errors++; $display("[TB] FAIL bp_release_valid_b got=%b exp=0", valid_b); end
    drive_beat(8'h10, 1'b0);
    drive_beat(8'h11, 1'b0);
    drive_beat(8'h12, 1'b0);
    drive_beat(8'h13, 1'b0);
    checks++;
    if (valid_b !== 1'b1 || data_b !== 32'h13121110) begin
      errors++; $display("[TB] FAIL bp_no_stray_beat got v=%b data=%h exp v=1 data=13121110", valid_b, data_b);
    end
    idle_cycle();
  endtask

  task automatic test_back_to_back();
    logic [7:0] vals [3];
    vals[0] = 8'h11; vals[1] = 8'h22; vals[2] = 8'h33;
    ready_b = 1'b1;
    for (int i = 0; i < 3; i++) begin
      valid_f = 1'b1;
      data_f  = vals[i];
      last_f  = 1'b1;
      @(posedge clk);
      #1;
      checks++;
      if (valid_b !== 1'b1 || data_b !== {24'h0, vals[i]} || keep_b !== 4'b0001 || last_b !== 1'b1) begin
        errors++;
        $display("[TB] FAIL b2b_word idx=%0d got v=%b data=%h keep=%b last=%b exp v=1 data=%h keep=0001 last=1",
                 i, valid_b, data_b, keep_b, last_b, {24'h0, vals[i]});
      end
    end
    valid_f = 1'b0;
    last_f  = 1'b0;
    idle_cycle();
    checks++;
    if (valid_b !== 1'b0) begin errors++; $display("[TB] FAIL b2b_drain got=%b exp=0", valid_b); end
  endtask

  task automatic test_gaps_reset();
    ready_b = 1'b1;
    drive_beat(8'h01, 1'b0);
    drive_beat(8'h02, 1'b0);
    for (int c = 0; c < 3; c++) begin
      idle_cycle();
      checks++;
      if (valid_b !== 1'b0) begin errors++; $display("[TB] FAIL gap_valid_b cycle=%0d got=%b exp=0", c, valid_b); end
    end
    rst = 1'b1;
    #1;
    checks++;
    if (ready_f !== 1'b0) begin errors++; $display("[TB] FAIL gap_rst_ready_f got=%b exp=0", ready_f); end
    @(posedge clk);
    #1;
    rst = 1'b0;
    checks++;
    if (valid_b !== 1'b0 || data_b !== 32'h0 || keep_b !== 4'h0 || last_b !== 1'b0 || dut.cnt_q !== 2'd0) begin
      errors++;
      $display("[TB] FAIL gap_after_reset got v=%b data=%h keep=%b last=%b cnt=%0d exp all zero",
               valid_b, data_b, keep_b, last_b, dut.cnt_q);
    end
    drive_beat(8'h05, 1'b0);
    drive_beat(8'h06, 1'b0);
    drive_beat(8'h07, 1'b0);
    drive_beat(8'h08, 1'b0);
    checks++;
    if (valid_b !== 1'b1 || data_b !== 32'h08070605 || keep_b !== 4'b1111 || last_b !== 1'b0) begin
      errors++;
      $display("[TB] FAIL gap_fresh_word got v=%b data=%h keep=%b last=%b exp v=1 data=08070605 keep=1111 last=0",
               valid_b, data_b, keep_b, last_b);
    end
    idle_cycle();
  endtask

  task automatic test_n2_boundary();
    rb2 = 1'b1;
    v2 = 1'b1; d2 = 8'h11; l2 = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (vb2 !== 1'b0) begin errors++; $display("[TB] FAIL n2_first_beat_valid got=%b exp=0", vb2); end
    d2 = 8'h22; l2 = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (vb2 !== 1'b1 || db2 !== 16'h2211 || kb2 !== 2'b11 || lb2 !== 1'b1) begin
      errors++;
      $display("[TB] FAIL n2_last_word got v=%b data=%h keep=%b last=%b exp v=1 data=2211 keep=11 last=1",
               vb2, db2, kb2, lb2);
    end
    d2 = 8'h33; l2 = 1'b0;
    @(posedge clk); #1;
    d2 = 8'h44;
    @(posedge clk); #1;
    checks++;
    if (vb2 !== 1'b1 || db2 !== 16'h4433 || kb2 !== 2'b11 || lb2 !== 1'b0) begin
      errors++;
      $display("[TB] FAIL n2_full_word got v=%b data=%h keep=%b last=%b exp v=1 data=4433 keep=11 last=0",
               vb2, db2, kb2, lb2);
    end
    v2 = 1'b0;
    @(posedge clk); #1;
  endtask

  initial begin
    test_reset();
    test_full_words();
    test_partial_flush();
    test_backpressure();
    test_back_to_back();
    test_gaps_reset();
    test_n2_boundary();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/beat_packer.md
# beat_packer

Downstream neighbour of the backward skid buffer. It consumes the narrow `L`-bit valid/ready stream that the skid buffer produces and packs `N` consecutive beats into one `N*L`-bit word. An optional `last_f` marker flushes a partial word early. The packed word is held in a registered output stage with its own valid/ready handshake.

## Interface
- `L`, default 8: width of one input beat in bits.
- `N`, default 4: beats per packed output word; legal range is N >= 2.
- `clk` input, 1 bit: single clock; every register updates on the rising edge.
- `rst` input, 1 bit: synchronous, active-high reset.
- `ready_f` output, 1 bit: the block can accept an input beat this cycle.
- `valid_f` input, 1 bit: an input beat is present.
- `data_f` input, L bits: input beat payload.
- `last_f` input, 1 bit: this beat closes the current word; qualified by `valid_f`.
- `ready_b` input, 1 bit: the consumer accepts the packed word this cycle.
- `valid_b` output, 1 bit: a packed word is present on `data_b`.
- `data_b` output, N*L bits: packed word.
- `keep_b` output, N bits: per-lane valid mask; bit i covers `data_b[i*L +: L]`.
- `last_b` output, 1 bit: the packed word was closed by `last_f`.

## Operation
- **Beat acceptance.** A beat is accepted when `valid_f && ready_f`.
- **Accumulator.**
  - Holds an N*L-bit accumulator plus lane counter `cnt`, which is `$clog2(N)` bits wide and runs 0..N-1.
  - An accepted beat is written into lane `cnt`. Lane 0 is bits [L-1:0], so packing is little-endian in arrival order.
- **Word completion.** An accepted beat completes the word when `cnt == N-1` or `last_f == 1`. On completion:
  - The output register loads the accumulator merged with the current beat. Lanes above `cnt` are forced to zero.
  - `keep_b` loads a mask with bits 0..cnt set.
  - `last_b` loads the current `last_f`.
  - `cnt` returns to 0 and the accumulator clears to zero.
- **Non-completing beat.** The beat is stored in its lane and `cnt` increments by 1. The output register is untouched.
- **Output register states.**
  - EMPTY (`valid_b=0`) goes to FULL when a word completes.
  - FULL goes to EMPTY when `ready_b=1` and no word completes this cycle.
  - FULL stays FULL when `ready_b=1` and a word completes this cycle. The register reloads in place with no bubble.
  - FULL stays FULL, contents held, when `ready_b=0`.
- **Backpressure.** `ready_f = !rst && (!valid_b || ready_b)`.
  - `ready_f` never depends on `valid_f`, `data_f` or `last_f`.
  - Input is stalled whenever the output word is waiting, even mid-word. This keeps the completion logic free of input-dependent ready.
- **Output stability.** While `valid_b && !ready_b`, the outputs `data_b`, `keep_b` and `last_b` hold stable.
- **Input gaps.** When `valid_f` drops mid-word, `cnt` and the accumulator hold indefinitely; there is no timeout and no flush.
- **Discarded inputs.** `data_f` and `last_f` are ignored in any cycle without acceptance.

## Timing
- **Reset values.** While `rst` is high, and on the first edge after it rises:
  - `valid_b=0`, `data_b=0`, `keep_b=0`, `last_b=0`, `cnt=0`, accumulator = 0.
  - `ready_f` is 0 combinationally during reset.
- **Mid-word reset.** Reset mid-word discards the partial word and any held output word. Nothing is emitted for them afterwards.
- **Latency.** The completing beat accepted at edge t produces `valid_b=1` from edge t (visible in cycle t+1). This is one register stage.
- **Throughput.** With `ready_b` held at 1, one input beat is accepted every cycle and one word is emitted every N cycles; there are no stall cycles.
- **Simultaneous events.**
  - Output handshake plus completion in the same cycle: the new word replaces the old one, and `valid_b` stays 1.
  - Output handshake with no completion: `valid_b` falls to 0 on the next edge.
- **Single-beat word.** `last_f` on the first beat of a word gives `keep_b` = 1 (lane 0 only), with the other lanes zero.
- **Full word closed by last.** `last_f` on beat N-1 gives `keep_b` all ones and `last_b=1`.

## Test plan
- **Full words.** L=8, N=4, `ready_b`=1, stream 0x01..0x08 with `last_f`=0 throughout -> two words 0x04030201 then 0x08070605, `keep_b`=4'b1111, `last_b`=0, one per 4 cycles, `ready_f` stuck at 1.
- **Partial flush.** Beats 0xAA, 0xBB with `last_f` on 0xBB -> `data_b`=0x0000BBAA, `keep_b`=4'b0011, `last_b`=1. The next beat 0xCC lands in lane 0.
- **Backpressure.** Complete a word with `ready_b`=0 held for 5 cycles -> `data_b` stays stable and `ready_f`=0 throughout. Release `ready_b` -> the word is accepted and `ready_f` returns to 1 in the same cycle.
- **Back-to-back reload.** Hold `ready_b`=1 and complete words on consecutive cycles using `last_f` on every beat (0x11, 0x22, 0x33) -> `valid_b` stays 1 for 3 cycles, `data_b` shows 0x11, 0x22, 0x33 in lane 0 and `keep_b`=4'b0001 each time.
- **Gaps and reset.** Send beats 0x01 and 0x02, drop `valid_f` for 3 cycles, then assert `rst` for 1 cycle -> after reset all outputs are 0 and `cnt`=0. Beats 0x05..0x08 then give 0x08070605 with no trace of 0x01 or 0x02.
- **Legal N boundary.** With N=2, beats 0x11, 0x22 and `last_f` on the 0x22 beat -> `data_b`=0x2211, `keep_b`=2'b11, `last_b`=1.
